// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// State enum, opcodes and datapath select codes live here.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR_ADDR,
    S_LUI_WB
  } state_t;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // States whose exit to FETCH completes an instruction
  function automatic logic is_terminal(
    input state_t s
  );
    return (s == S_MEM_WB)    ||
           (s == S_MEM_WRITE) ||
           (s == S_ALU_WB)    ||
           (s == S_BRANCH)    ||
           (s == S_LUI_WB);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_branch_resolver.sv
// Conditional-branch decision from funct3 and ALU flags.
// Reduced build resolves beq only.
module multi_cycle_controller_branch_resolver #(
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_neg,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      3'b000:  o_taken = i_zero;
      3'b001:  o_taken = BRANCH_FULL && !i_zero;
      3'b100:  o_taken = BRANCH_FULL && i_neg;
      3'b101:  o_taken = BRANCH_FULL && !i_neg;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing a shared-resource RV32I datapath,
// with memory handshake and a retired-instruction counter.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter bit SUPPORT_JALR = 1'b1,
  parameter bit BRANCH_FULL  = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opc,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_taken;
  logic             w_retire;

  logic w_is_ls;
  logic w_is_sw;
  logic w_is_r;
  logic w_is_i;
  logic w_is_b;
  logic w_is_jal;
  logic w_is_lui;
  logic w_is_jalr;

  assign w_is_sw   = (opc == OPC_SW);
  assign w_is_ls   = (opc == OPC_LW) || w_is_sw;
  assign w_is_r    = (opc == OPC_R);
  assign w_is_i    = (opc == OPC_I);
  assign w_is_b    = (opc == OPC_B);
  assign w_is_jal  = (opc == OPC_JAL);
  assign w_is_lui  = (opc == OPC_LUI);
  assign w_is_jalr = SUPPORT_JALR &&
                     (opc == OPC_JALR);

  multi_cycle_controller_branch_resolver #(
    .BRANCH_FULL (BRANCH_FULL)
  ) u_branch (
    .i_funct3 (funct3),
    .i_zero   (zero),
    .i_neg    (neg),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  assign w_retire = is_terminal(r_state) &&
                    (w_state_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst)
      r_retired <= '0;
    else if (w_retire)
      r_retired <= r_retired + CNT_W'(1);
  end

  assign retired = r_retired;

  always_comb begin
    w_state_next  = r_state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    illegal_instr = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready)
          w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target precomputed into ALUOut
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        imm_src   = w_is_jal ? IMM_J : IMM_B;
        unique case (1'b1)
          w_is_ls:   w_state_next = S_MEM_ADDR;
          w_is_r:    w_state_next = S_EXEC_R;
          w_is_i:    w_state_next = S_EXEC_I;
          w_is_b:    w_state_next = S_BRANCH;
          w_is_jal:  w_state_next = S_JAL;
          w_is_lui:  w_state_next = S_LUI_WB;
          w_is_jalr: w_state_next = S_JALR_ADDR;
          default: begin
            illegal_instr = 1'b1;
            w_state_next  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        imm_src      = w_is_sw ? IMM_S : IMM_I;
        w_state_next = w_is_sw ? S_MEM_WRITE
                               : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)
          w_state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src   = RES_DATA;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready)
          w_state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_RTYPE;
        w_state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ITYPE;
        imm_src      = IMM_I;
        w_state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src   = RES_ALUOUT;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_SUB;
        result_src   = RES_ALUOUT;
        pc_write     = w_taken;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes target from ALUOut; ALU forms OldPC+4 for rd
        alu_src_a    = SRC_A_OLDPC;
        alu_src_b    = SRC_B_FOUR;
        alu_op       = ALU_ADD;
        result_src   = RES_ALUOUT;
        pc_write     = 1'b1;
        w_state_next = S_ALU_WB;
      end
      S_JALR_ADDR: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        imm_src      = IMM_I;
        w_state_next = S_JAL;
      end
      S_LUI_WB: begin
        imm_src      = IMM_U;
        result_src   = RES_IMM;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase

    if (rst) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      imm_src       = 3'b000;
      result_src    = 2'b00;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: full and reduced builds
// checked cycle by cycle against an instruction-level model.
module tb_multi_cycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rgw;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [2:0] imm;
    logic [1:0] res;
    logic       ill;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   kind;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opc = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;

  logic        d0_mreq, d0_mwr, d0_adr, d0_irw;
  logic        d0_pcw, d0_rgw, d0_ill;
  logic [1:0]  d0_a, d0_b, d0_op, d0_res;
  logic [2:0]  d0_imm;
  logic [31:0] d0_ret;
  logic        d1_mreq, d1_mwr, d1_adr, d1_irw;
  logic        d1_pcw, d1_rgw, d1_ill;
  logic [1:0]  d1_a, d1_b, d1_op, d1_res;
  logic [2:0]  d1_imm;
  logic [31:0] d1_ret;

  ctl_t        obs0, obs1, obs;
  logic [31:0] obs_ret;
  int          sel = 0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;
  step_t       q[$];
  bit          legal;

  always #5 clk = ~clk;

  multi_cycle_controller u_dut0 (
    .clk(clk), .rst(rst), .opc(opc),
    .funct3(funct3), .zero(zero), .neg(neg),
    .mem_ready(mem_ready),
    .mem_req(d0_mreq), .mem_write(d0_mwr),
    .adr_src(d0_adr), .ir_write(d0_irw),
    .pc_write(d0_pcw), .reg_write(d0_rgw),
    .alu_src_a(d0_a), .alu_src_b(d0_b),
    .alu_op(d0_op), .imm_src(d0_imm),
    .result_src(d0_res),
    .illegal_instr(d0_ill), .retired(d0_ret)
  );

  multi_cycle_controller #(
    .SUPPORT_JALR(1'b0), .BRANCH_FULL(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .opc(opc),
    .funct3(funct3), .zero(zero), .neg(neg),
    .mem_ready(mem_ready),
    .mem_req(d1_mreq), .mem_write(d1_mwr),
    .adr_src(d1_adr), .ir_write(d1_irw),
    .pc_write(d1_pcw), .reg_write(d1_rgw),
    .alu_src_a(d1_a), .alu_src_b(d1_b),
    .alu_op(d1_op), .imm_src(d1_imm),
    .result_src(d1_res),
    .illegal_instr(d1_ill), .retired(d1_ret)
  );

  assign obs0 = {d0_mreq, d0_mwr, d0_adr, d0_irw,
                 d0_pcw, d0_rgw, d0_a, d0_b, d0_op,
                 d0_imm, d0_res, d0_ill};
  assign obs1 = {d1_mreq, d1_mwr, d1_adr, d1_irw,
                 d1_pcw, d1_rgw, d1_a, d1_b, d1_op,
                 d1_imm, d1_res, d1_ill};
  assign obs     = (sel != 0) ? obs1 : obs0;
  assign obs_ret = (sel != 0) ? d1_ret : d0_ret;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  // flags = {mreq,mwr,adr,irw,pcw,rgw}
  function automatic ctl_t mk(
    input logic [5:0] f,
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] op,
    input logic [2:0] imm,
    input logic [1:0] res,
    input logic       ill
  );
    ctl_t c;
    {c.mreq, c.mwr, c.adr, c.irw, c.pcw, c.rgw} = f;
    c.a = a; c.b = b; c.op = op;
    c.imm = imm; c.res = res; c.ill = ill;
    return c;
  endfunction

  // kind: 0 = single cycle, 1 = memory wait, 2 = fetch
  task automatic push(input ctl_t c, input int k);
    step_t s;
    s.c = c;
    s.kind = k;
    q.push_back(s);
  endtask

  task automatic model(input logic [6:0] o,
                       input logic [2:0] f3,
                       input logic z, input logic n);
    bit   full = (sel == 0);
    bit   jok  = (sel == 0);
    bit   tk;
    ctl_t dec, aluwb, jalc;
    q.delete();
    legal = 1'b1;
    tk = (f3 == 3'd0) ? z :
         (!full) ? 1'b0 :
         (f3 == 3'd1) ? !z :
         (f3 == 3'd4) ? n :
         (f3 == 3'd5) ? !n : 1'b0;
    dec   = mk(6'b0, 2'b01, 2'b01, 2'b00,
               (o == JAL) ? 3'b100 : 3'b010, 2'b00, 0);
    aluwb = mk(6'b000001, 0, 0, 0, 0, 2'b00, 0);
    jalc  = mk(6'b000010, 2'b01, 2'b10, 2'b00,
               0, 2'b00, 0);
    push(mk(6'b100000, 2'b00, 2'b10, 2'b00,
            0, 2'b10, 0), 2);
    if (o == LW) begin
      push(dec, 0);
      push(mk(0, 2'b10, 2'b01, 0, 3'b000, 0, 0), 0);
      push(mk(6'b101000, 0, 0, 0, 0, 0, 0), 1);
      push(mk(6'b000001, 0, 0, 0, 0, 2'b01, 0), 0);
    end else if (o == SW) begin
      push(dec, 0);
      push(mk(0, 2'b10, 2'b01, 0, 3'b001, 0, 0), 0);
      push(mk(6'b111000, 0, 0, 0, 0, 0, 0), 1);
    end else if (o == RT) begin
      push(dec, 0);
      push(mk(0, 2'b10, 2'b00, 2'b10, 0, 0, 0), 0);
      push(aluwb, 0);
    end else if (o == IT) begin
      push(dec, 0);
      push(mk(0, 2'b10, 2'b01, 2'b11, 0, 0, 0), 0);
      push(aluwb, 0);
    end else if (o == BR) begin
      push(dec, 0);
      push(mk({4'b0, tk, 1'b0}, 2'b10, 2'b00,
              2'b01, 0, 2'b00, 0), 0);
    end else if (o == JAL) begin
      push(dec, 0);
      push(jalc, 0);
      push(aluwb, 0);
    end else if (o == LUI) begin
      push(dec, 0);
      push(mk(6'b000001, 0, 0, 0, 3'b011, 2'b11, 0), 0);
    end else if (o == JALR && jok) begin
      push(dec, 0);
      push(mk(0, 2'b10, 2'b01, 2'b00, 0, 0, 0), 0);
      push(jalc, 0);
      push(aluwb, 0);
    end else begin
      dec.ill = 1'b1;
      push(dec, 0);
      legal = 1'b0;
    end
  endtask

  task automatic cyc(input ctl_t e, input int i);
    #1;
    chk($sformatf("dut%0d opc=%b f3=%b step%0d",
                  sel, opc, funct3, i),
        32'(obs), 32'(e));
    @(negedge clk);
  endtask

  // Runs one instruction; stop >= 0 abandons it at that step
  task automatic run(input logic [6:0] o,
                     input logic [2:0] f3,
                     input logic z, input logic n,
                     input int wf, input int wm,
                     input int stop);
    model(o, f3, z, n);
    opc = o; funct3 = f3; zero = z; neg = n;
    chk($sformatf("dut%0d retired", sel),
        obs_ret, exp_ret);
    for (int i = 0; i < q.size(); i++) begin
      ctl_t e;
      int   nw;
      if (i == stop) begin
        mem_ready = 1'b0;
        cyc(q[i].c, i);
        return;
      end
      if (q[i].kind == 0) begin
        mem_ready = 1'($urandom_range(0, 1));
        cyc(q[i].c, i);
      end else begin
        nw = (q[i].kind == 2) ? wf : wm;
        for (int k = 0; k <= nw; k++) begin
          e = q[i].c;
          mem_ready = (k == nw);
          if (q[i].kind == 2 && k == nw) begin
            e.irw = 1'b1;
            e.pcw = 1'b1;
          end
          cyc(e, i);
        end
      end
    end
    if (legal) exp_ret = exp_ret + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("reset ctl", 32'(obs), 32'd0);
      if (k == 1)
        chk("reset retired", obs_ret, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    exp_ret = '0;
  endtask

  task automatic rand_run(input int n);
    logic [6:0] tbl [9];
    tbl = '{LW, SW, RT, IT, BR, LUI, JAL, JALR, 7'h7f};
    for (int j = 0; j < n; j++) begin
      int         idx;
      logic [6:0] o;
      idx = $urandom_range(0, 9);
      o = (idx == 9) ? 7'($urandom) : tbl[idx];
      run(o, 3'($urandom), 1'($urandom),
          1'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    @(negedge clk);
    sel = 0;
    do_reset();
    run(RT,   3'd0, 0, 0, 0, 0, -1);
    run(LW,   3'd2, 0, 0, 0, 3, -1);
    run(BR,   3'd1, 0, 0, 0, 0, -1);
    run(BR,   3'd1, 1, 0, 0, 0, -1);
    run(BR,   3'd5, 0, 0, 1, 0, -1);
    run(JALR, 3'd0, 0, 0, 0, 0, -1);
    run(JAL,  3'd0, 0, 0, 2, 0, -1);
    run(LUI,  3'd0, 0, 0, 0, 0, -1);
    run(SW,   3'd2, 0, 0, 0, 2, -1);
    run(IT,   3'd0, 0, 0, 0, 0, -1);
    run(7'h7f, 3'd0, 0, 0, 0, 0, -1);
    rand_run(60);
    run(SW,   3'd2, 0, 0, 0, 5, 3);
    do_reset();
    run(RT,   3'd0, 0, 0, 0, 0, -1);

    sel = 1;
    do_reset();
    run(BR,   3'd5, 0, 0, 0, 0, -1);
    run(BR,   3'd1, 0, 0, 0, 0, -1);
    run(BR,   3'd0, 1, 0, 0, 0, -1);
    run(JALR, 3'd0, 0, 0, 0, 0, -1);
    run(RT,   3'd0, 0, 0, 0, 0, -1);
    rand_run(40);
    run(RT,   3'd0, 0, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
